// File: rtl/scan_display.sv
// rtl/scan_display.sv - 4-digit common-anode 7-segment scanner with frame snapshot, hold, zero blanking and blink
module scan_display #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       hold,
  input  logic       blank_lz,
  input  logic [3:0] blink_mask,
  input  logic [3:0] dp_mask,
  output logic [3:0] ssd_ctl,
  output logic [7:0] ssd_seg
);

  localparam int SCAN_W  = $clog2(SCAN_DIV);
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [3:0][3:0]    snap_q, snap_d;
  logic [3:0]         ssd_ctl_q, ssd_ctl_d;
  logic [7:0]         ssd_seg_q, ssd_seg_d;

  logic       scan_tick;
  logic       frame_end;
  logic [3:0] lz_blank;
  logic [3:0] cur_digit;
  logic       blanked;
  logic [6:0] seg_code;

  always_comb begin
    scan_tick     = (scan_cnt_q == SCAN_LAST);
    frame_end     = scan_tick && (sel_q == 2'd3);
    scan_cnt_d    = scan_tick ? '0 : scan_cnt_q + 1'b1;
    sel_d         = scan_tick ? sel_q + 2'd1 : sel_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (scan_tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    // Inputs are only captured at the frame boundary so a frame never tears.
    snap_d = snap_q;
    if (frame_end && !hold) begin
      snap_d = {digit3, digit2, digit1, digit0};
    end
  end

  always_comb begin
    cur_digit   = snap_q[sel_q];
    lz_blank[3] = blank_lz && (snap_q[3] == 4'd0);
    lz_blank[2] = lz_blank[3] && (snap_q[2] == 4'd0);
    lz_blank[1] = lz_blank[2] && (snap_q[1] == 4'd0);
    lz_blank[0] = 1'b0;
    blanked     = (blink_mask[sel_q] && blink_phase_q) || lz_blank[sel_q];
    case (cur_digit)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h3F;
    endcase
    if (blanked) begin
      ssd_ctl_d = 4'hF;
      ssd_seg_d = 8'hFF;
    end else begin
      ssd_ctl_d        = 4'hF;
      ssd_ctl_d[sel_q] = 1'b0;
      ssd_seg_d        = {~dp_mask[sel_q], seg_code};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      sel_q         <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      snap_q        <= '0;
      ssd_ctl_q     <= 4'hF;
      ssd_seg_q     <= 8'hFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      snap_q        <= snap_d;
      ssd_ctl_q     <= ssd_ctl_d;
      ssd_seg_q     <= ssd_seg_d;
    end
  end

  assign ssd_ctl = ssd_ctl_q;
  assign ssd_seg = ssd_seg_q;

endmodule

// File: tb/tb_scan_display.sv
// tb/tb_scan_display.sv - scoreboard bench for scan_display with SCAN_DIV=4, BLINK_DIV=4
module tb_scan_display;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       hold, blank_lz;
  logic [3:0] blink_mask, dp_mask;
  logic [3:0] ssd_ctl;
  logic [7:0] ssd_seg;

  scan_display #(.SCAN_DIV(4), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .hold(hold), .blank_lz(blank_lz), .blink_mask(blink_mask), .dp_mask(dp_mask),
    .ssd_ctl(ssd_ctl), .ssd_seg(ssd_seg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] tag;
    logic [3:0] ctl;
    logic [7:0] seg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec    = 0;
  int   n_bad    = 0;
  int   frame_id = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      if (ssd_ctl !== mon_e.ctl || ssd_seg !== mon_e.seg) begin
        n_bad++;
        $display("FAIL frame%0d t=%0t: ctl/seg got %b/%h want %b/%h",
                 mon_e.tag, $time, ssd_ctl, ssd_seg, mon_e.ctl, mon_e.seg);
      end
    end
  end

  task automatic cycle(input logic [3:0] ctl, input logic [7:0] seg);
    exp_t e;
    @(posedge clk);
    #1;
    e.tag = frame_id[7:0];
    e.ctl = ctl;
    e.seg = seg;
    exp_q.push_back(e);
  endtask

  task automatic slot_cycles(input int cnt, input int n, input logic [7:0] seg);
    logic [3:0] ctl;
    ctl    = 4'hF;
    ctl[n] = 1'b0;
    for (int c = 0; c < cnt; c++) cycle(ctl, seg);
  endtask

  // One full frame: slot n shows segs[n] when lit[n], otherwise fully dark.
  task automatic frame(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                       input logic [7:0] s3, input logic [3:0] lit, input bit hold_last);
    logic [7:0] segs [4];
    logic [3:0] ctl;
    segs[0] = s0; segs[1] = s1; segs[2] = s2; segs[3] = s3;
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (hold_last && n == 3 && c == 3) hold = 1'b1;
        ctl    = 4'hF;
        ctl[n] = 1'b0;
        if (lit[n]) cycle(ctl, segs[n]);
        else        cycle(4'hF, 8'hFF);
      end
    end
    frame_id++;
  endtask

  task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0; blank_lz = 1'b0; blink_mask = 4'h0; dp_mask = 4'h0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) cycle(4'hF, 8'hFF);
    rst_n = 1'b1;

    // Digits set during frame k are displayed in frame k+1.
    set_digits(4'd4, 4'd3, 4'd2, 4'd1);
    frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 4'hF, 1'b0);
    set_digits(4'd8, 4'd7, 4'd6, 4'd5);
    frame(8'hF9, 8'hA4, 8'hB0, 8'h99, 4'hF, 1'b0);
    set_digits(4'd9, 4'd0, 4'd9, 4'd0);
    frame(8'h92, 8'h82, 8'hF8, 8'h80, 4'hF, 1'b0);
    set_digits(4'd0, 4'd0, 4'd5, 4'd0);
    frame(8'hC0, 8'h90, 8'hC0, 8'h90, 4'hF, 1'b0);

    blank_lz = 1'b1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    frame(8'hC0, 8'h92, 8'hFF, 8'hFF, 4'b0011, 1'b0);
    set_digits(4'd1, 4'd2, 4'd3, 4'd4);
    frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 4'b0001, 1'b0);

    // Hold rises in the boundary cycle itself, so 5678 must never be captured.
    blank_lz = 1'b0;
    set_digits(4'd5, 4'd6, 4'd7, 4'd8);
    frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 1'b1);
    frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 1'b0);
    hold = 1'b0;
    frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 4'hF, 1'b0);

    // Blink phase is 1 in odd frames counted from reset release.
    blink_mask = 4'b0001;
    frame(8'h80, 8'hF8, 8'h82, 8'h92, 4'b1110, 1'b0);
    frame(8'h80, 8'hF8, 8'h82, 8'h92, 4'hF,    1'b0);
    frame(8'h80, 8'hF8, 8'h82, 8'h92, 4'b1110, 1'b0);

    blink_mask = 4'b0000;
    dp_mask    = 4'b0010;
    set_digits(4'd5, 4'd6, 4'd3, 4'hC);
    frame(8'h80, 8'h78, 8'h82, 8'h92, 4'hF, 1'b0);
    frame(8'hBF, 8'h30, 8'h82, 8'h92, 4'hF, 1'b0);

    slot_cycles(4, 0, 8'hBF);
    slot_cycles(2, 1, 8'h30);
    rst_n = 1'b0;
    cycle(4'hF, 8'hFF);
    rst_n = 1'b1;
    frame_id = 100;
    frame(8'hC0, 8'h40, 8'hC0, 8'hC0, 4'hF, 1'b0);
    frame(8'hBF, 8'h30, 8'h82, 8'h92, 4'hF, 1'b0);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
